pconv_mac_unit: RTL
===================

Name: pconv_mac_unit

Overview:
- Parametrised successor to the single-product point-wise conv unit.
- Streams IN_CH (activation, weight) pairs per output pixel, multiplies them, and accumulates the products in a wide signed accumulator.
- On completion it adds bias, applies a rounded arithmetic right shift, optionally applies ReLU, saturates to N bits, and emits one valid output pulse.
- Sits between the line/window buffers and the pooling stage; IN_CH=1 gives the single-channel case.

Parameters:
- N, 16, signed fixed-point data width of activations, weights and output.
- IN_CH, 4, input channels accumulated per output pixel (>=1).
- ACC_W, 40, accumulator width; must be >= 2N + clog2(IN_CH).
- SHIFT_W, 5, width of the shift amount.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  clock enable; 0 freezes every register.
- input_vld  in  1  input pair valid.
- input_din  in  N  signed activation.
- weight_din  in  N  signed weight.
- bias_din  in  ACC_W  signed bias, already aligned to the product scale.
- shift_din  in  SHIFT_W  right-shift amount.
- relu_en  in  1  1 = clamp negative results to 0.
- conv_dout  out  N  signed result.
- conv_dout_vld  out  1  one-cycle result strobe.
- busy  out  1  a pixel is partially accumulated or still in flight.

Behaviour:
- Reset values: all pipeline registers and the channel counter are 0; conv_dout=0, conv_dout_vld=0, busy=0.
- A pair is accepted when ce=1 and input_vld=1 in the same cycle.
- Channel counter counts 0..IN_CH-1 and wraps to 0 after the last channel.
- bias_din, shift_din and relu_en are sampled on the channel-0 pair and held for that pixel.
- Pipeline stages:
  - S1: registered signed product, 2N bits.
  - S2: accumulator. On channel 0, acc = sign-extended product; on later channels, acc = acc + product.
  - S3: output register, loaded one cycle after the last channel's accumulate.
- Latency: last pair accepted at cycle T gives conv_dout_vld=1 at T+3 (cycles counted with ce=1).
- Output arithmetic:
  - s = acc + bias, computed at ACC_W+1 bits.
  - If shift>0, r = (s + 2^(shift-1)) >>> shift; otherwise r = s (round half up, arithmetic shift).
  - If relu_en=1 and r<0, r = 0.
  - Saturate r to [-2^(N-1), 2^(N-1)-1].
- conv_dout holds its value until the next result; conv_dout_vld is high for exactly one ce=1 cycle per pixel.
- Back-to-back pixels: channel 0 of pixel k+1 may be accepted in the cycle right after the last pair of pixel k. No bubble is required, and outputs are then spaced IN_CH cycles apart.
- Gaps: input_vld=0 cycles inside a pixel are allowed; the counter and accumulator hold.
- ce=0 stall: all state freezes, including conv_dout_vld. Downstream qualifies conv_dout_vld with ce. Results are identical to the unstalled case, only delayed.
- busy = (counter != 0) OR any of S1–S3 holds a valid token.
- rst mid-pixel: partial sum is discarded, counter returns to 0, no conv_dout_vld is produced for that pixel. The next accepted pair is treated as channel 0.
- IN_CH=1: every accepted pair is a complete pixel.

Test Plan:
- Basic MAC (N=16, IN_CH=4): inputs 2,3,-1,4, weights all 5, bias 8, shift 2, relu_en=0 -> conv_dout=12, with conv_dout_vld exactly 3 cycles after the 4th pair.
- ReLU: inputs all -10, weights all 100, bias 0, shift 0 -> relu_en=1 gives 0; relu_en=0 gives -4000 (0xF060).
- Saturation and rounding:
  - inputs/weights all 1000, bias 0, shift 0 -> 32767.
  - same values negated on inputs, relu_en=0 -> -32768.
  - a single-channel result of acc=-5 with shift 1 -> -2.
- Streaming: 3 pixels fed back-to-back with no gaps -> 3 vld pulses spaced 4 cycles apart with correct values; busy drops 3 cycles after the final pair.
- Stall and gaps: ce=0 for 3 cycles plus input_vld=0 for 2 cycles mid-pixel -> same result as the basic MAC case, vld delayed by 5 cycles.
- Reset mid-pixel: assert rst after 2 pairs -> no vld and busy=0; next 4 pairs from the basic MAC case -> 12.

Source files
------------

// File: rtl/pconv_mac_unit_if.sv
// Stream-side bundle of the point-wise conv MAC: activation/weight pairs and per-pixel
// configuration flow in from the window buffers, results flow out toward pooling.
interface pconv_mac_unit_if #(
    parameter int N       = 16,
    parameter int ACC_W   = 40,
    parameter int SHIFT_W = 5
);
    logic                      input_vld;
    logic signed [N-1:0]       input_din;
    logic signed [N-1:0]       weight_din;
    logic signed [ACC_W-1:0]   bias_din;
    logic        [SHIFT_W-1:0] shift_din;
    logic                      relu_en;
    logic signed [N-1:0]       conv_dout;
    logic                      conv_dout_vld;
    logic                      busy;

    modport master (
        output input_vld, input_din, weight_din, bias_din, shift_din, relu_en,
        input  conv_dout, conv_dout_vld, busy
    );

    modport slave (
        input  input_vld, input_din, weight_din, bias_din, shift_din, relu_en,
        output conv_dout, conv_dout_vld, busy
    );
endinterface

// File: rtl/pconv_mac_unit.sv
// Multi-channel point-wise conv MAC: multiply, accumulate IN_CH channels, then
// bias, rounded shift, optional ReLU and saturation into one strobed result.
module pconv_mac_unit #(
    parameter int N       = 16,
    parameter int IN_CH   = 4,
    parameter int ACC_W   = 40,
    parameter int SHIFT_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    pconv_mac_unit_if.slave bus
);
    localparam int CNT_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int OUT_W = ACC_W + 2;
    localparam logic signed [OUT_W-1:0] SAT_MAX = {{(OUT_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {{(OUT_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [2*N-1:0]     prod_q, prod_d;
    logic                      s1_vld_q, s1_vld_d;
    logic                      s1_first_q, s1_first_d;
    logic                      s1_last_q, s1_last_d;
    logic signed [ACC_W-1:0]   s1_bias_q, s1_bias_d;
    logic        [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
    logic                      s1_relu_q, s1_relu_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      s2_last_q, s2_last_d;
    logic signed [ACC_W-1:0]   s2_bias_q, s2_bias_d;
    logic        [SHIFT_W-1:0] s2_shift_q, s2_shift_d;
    logic                      s2_relu_q, s2_relu_d;
    logic signed [N-1:0]       dout_q, dout_d;
    logic                      dout_vld_q, dout_vld_d;

    logic                      accept;
    logic                      first_ch;
    logic                      last_ch;
    logic                      adv1;
    logic signed [2*N-1:0]     a_ext;
    logic signed [2*N-1:0]     w_ext;
    logic signed [OUT_W-1:0]   sum_s;
    logic signed [OUT_W-1:0]   rnd;
    logic signed [OUT_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   relu_r;
    logic signed [N-1:0]       sat_val;

    // Input side: channel counter, S1 product and channel-0 config capture.
    always_comb begin
        accept   = ce & bus.input_vld;
        first_ch = (cnt_q == '0);
        last_ch  = (cnt_q == CNT_W'(IN_CH - 1));
        a_ext    = {{N{bus.input_din[N-1]}}, bus.input_din};
        w_ext    = {{N{bus.weight_din[N-1]}}, bus.weight_din};

        cnt_d      = cnt_q;
        prod_d     = prod_q;
        s1_vld_d   = s1_vld_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_bias_d  = s1_bias_q;
        s1_shift_d = s1_shift_q;
        s1_relu_d  = s1_relu_q;

        if (ce) begin
            s1_vld_d = accept;
        end
        if (accept) begin
            cnt_d      = last_ch ? '0 : cnt_q + CNT_W'(1);
            prod_d     = a_ext * w_ext;
            s1_first_d = first_ch;
            s1_last_d  = last_ch;
            if (first_ch) begin
                s1_bias_d  = bus.bias_din;
                s1_shift_d = bus.shift_din;
                s1_relu_d  = bus.relu_en;
            end
        end
    end

    // Config travels with the channel-0 token so a back-to-back pixel cannot
    // overwrite the settings of the pixel still being finished.
    always_comb begin
        adv1 = ce & s1_vld_q;

        acc_d      = acc_q;
        s2_last_d  = s2_last_q;
        s2_bias_d  = s2_bias_q;
        s2_shift_d = s2_shift_q;
        s2_relu_d  = s2_relu_q;

        if (ce) begin
            s2_last_d = s1_vld_q & s1_last_q;
        end
        if (adv1) begin
            if (s1_first_q) begin
                acc_d      = ACC_W'(prod_q);
                s2_bias_d  = s1_bias_q;
                s2_shift_d = s1_shift_q;
                s2_relu_d  = s1_relu_q;
            end else begin
                acc_d = acc_q + ACC_W'(prod_q);
            end
        end
    end

    // Output arithmetic: bias, round-half-up arithmetic shift, ReLU, saturate.
    always_comb begin
        sum_s = OUT_W'(acc_q) + OUT_W'(s2_bias_q);
        rnd   = '0;
        if (s2_shift_q != '0) begin
            rnd = OUT_W'(1) << (s2_shift_q - SHIFT_W'(1));
        end
        shifted = (sum_s + rnd) >>> s2_shift_q;
        relu_r  = (s2_relu_q && (shifted < 0)) ? '0 : shifted;

        if (relu_r > SAT_MAX) begin
            sat_val = {1'b0, {(N-1){1'b1}}};
        end else if (relu_r < SAT_MIN) begin
            sat_val = {1'b1, {(N-1){1'b0}}};
        end else begin
            sat_val = relu_r[N-1:0];
        end

        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        if (ce) begin
            dout_vld_d = s2_last_q;
            if (s2_last_q) begin
                dout_d = sat_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            prod_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bias_q  <= '0;
            s1_shift_q <= '0;
            s1_relu_q  <= 1'b0;
            acc_q      <= '0;
            s2_last_q  <= 1'b0;
            s2_bias_q  <= '0;
            s2_shift_q <= '0;
            s2_relu_q  <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            s1_vld_q   <= s1_vld_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_bias_q  <= s1_bias_d;
            s1_shift_q <= s1_shift_d;
            s1_relu_q  <= s1_relu_d;
            acc_q      <= acc_d;
            s2_last_q  <= s2_last_d;
            s2_bias_q  <= s2_bias_d;
            s2_shift_q <= s2_shift_d;
            s2_relu_q  <= s2_relu_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign bus.conv_dout     = dout_q;
    assign bus.conv_dout_vld = dout_vld_q;
    assign bus.busy          = (cnt_q != '0) | s1_vld_q | s2_last_q | dout_vld_q;
endmodule
